// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Each accepted operation returns one registered response tagged with the requester id.
//
// state | meaning
// IDLE  | waiting for a request; the granted requester sees ready
// EXEC  | registered operands are stable at the ALU; the result is captured at the next edge
// RESP  | response held valid until the consumer takes it
module alu_arbiter #(
  parameter int WIDTH = 5,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SEL_W-1:0] req0_s,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SEL_W-1:0] req1_s,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_cin,
  output logic [SEL_W-1:0] alu_s,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_last_id;
  logic [SEL_W-1:0] r_alu_s;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic             r_alu_cin;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_f;
  logic             r_rsp_cout;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // On a tie the requester that was not served last wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | r_last_id);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_id);

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_id   <= 1'b1;
      r_alu_s     <= '0;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_alu_cin   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_f     <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0) begin
            r_alu_s   <= req0_s;
            r_alu_x   <= req0_x;
            r_alu_y   <= req0_y;
            r_alu_cin <= req0_cin;
            r_rsp_id  <= 1'b0;
            r_last_id <= 1'b0;
            r_state   <= S_EXEC;
          end else if (w_grant1) begin
            r_alu_s   <= req1_s;
            r_alu_x   <= req1_x;
            r_alu_y   <= req1_y;
            r_alu_cin <= req1_cin;
            r_rsp_id  <= 1'b1;
            r_last_id <= 1'b1;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_f     <= alu_f;
          r_rsp_cout  <= alu_cout;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_s     = r_alu_s;
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign alu_cin   = r_alu_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_f     = r_rsp_f;
  assign rsp_cout  = r_rsp_cout;
  assign busy      = ~w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in combinational ALU, a transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_alu_arbiter;
  localparam int W = 5;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid, req0_cin, req1_cin;
  logic [S-1:0] req0_s, req1_s;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         req0_ready, req1_ready;
  logic [S-1:0] alu_s;
  logic [W-1:0] alu_x, alu_y, alu_f, rsp_f;
  logic         alu_cin, alu_cout;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ALU: 0 add with carry, 1 subtract (x + ~y + cin), 2 and, 3 xor
  function automatic logic [W:0] alu_fn(logic [S-1:0] s, logic [W-1:0] x, logic [W-1:0] y, logic c);
    case (s)
      2'd0:    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      2'd1:    return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, c};
      2'd2:    return {1'b0, x & y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  assign {alu_cout, alu_f} = alu_fn(alu_s, alu_x, alu_y, alu_cin);

  alu_arbiter #(.WIDTH(W), .SEL_W(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s(req0_s),
    .req0_x(req0_x), .req0_y(req0_y), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s(req1_s),
    .req1_x(req1_x), .req1_y(req1_y), .req1_cin(req1_cin),
    .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction, tracked as "in flight" plus "response shown".
  bit           m_on = 0;
  bit           m_busy, m_rv, m_last, m_id, m_cout, m_cin;
  logic [S-1:0] m_s;
  logic [W-1:0] m_x, m_y, m_f;
  logic [W:0]   m_pend;
  int           acc_id[$];
  int           acc_cyc[$];

  always @(posedge clk) begin : model
    bit g0, g1, e0, e1;
    cyc++;
    g0 = 0; g1 = 0;
    if (!m_busy) begin
      if (req0_valid && req1_valid) begin
        g0 = m_last; g1 = !m_last;
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
    end
    if (rst) begin
      m_on = 1; m_busy = 0; m_rv = 0; m_last = 1; m_id = 0;
      m_f = '0; m_cout = 0; m_s = '0; m_x = '0; m_y = '0; m_cin = 0;
    end else if (m_on) begin
      if (g0 || g1) begin
        m_id   = g1;
        m_last = g1;
        m_s    = g1 ? req1_s : req0_s;
        m_x    = g1 ? req1_x : req0_x;
        m_y    = g1 ? req1_y : req0_y;
        m_cin  = g1 ? req1_cin : req0_cin;
        m_pend = alu_fn(m_s, m_x, m_y, m_cin);
        m_busy = 1;
        acc_id.push_back(int'(g1));
        acc_cyc.push_back(cyc);
      end else if (m_busy) begin
        if (!m_rv) begin
          m_rv = 1; m_f = m_pend[W-1:0]; m_cout = m_pend[W];
        end else if (rsp_ready) begin
          m_rv = 0; m_busy = 0;
        end
      end
    end
    #1;
    if (m_on) begin
      e0 = 0; e1 = 0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          e0 = m_last; e1 = !m_last;
        end else begin
          e0 = req0_valid; e1 = req1_valid;
        end
      end
      chk("m_busy", busy, m_busy);
      chk("m_rsp_valid", rsp_valid, m_rv);
      chk("m_rsp_id", rsp_id, m_id);
      chk("m_rsp_f", rsp_f, m_f);
      chk("m_rsp_cout", rsp_cout, m_cout);
      chk("m_alu_ops", {alu_s, alu_x, alu_y, alu_cin}, {m_s, m_x, m_y, m_cin});
      chk("m_req0_ready", req0_ready, e0);
      chk("m_req1_ready", req1_ready, e1);
    end
  end

  task automatic wait_ready(input bit which, output bit ok);
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if ((which ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
    chk(which ? "timeout_req1_ready" : "timeout_req0_ready", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int base, n, h;
    logic [W-1:0] sv_f;
    logic sv_id, sv_c;

    rst = 1; rsp_ready = 0;
    req0_valid = 0; req0_s = '0; req0_x = '0; req0_y = '0; req0_cin = 0;
    req1_valid = 0; req1_s = '0; req1_x = '0; req1_y = '0; req1_cin = 0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_s, alu_x, alu_y, alu_cin}, 0);
    rst = 0;

    // single op from requester 0: 3 + 4 + 1 = 8, no carry
    @(negedge clk);
    rsp_ready = 1;
    req0_valid = 1; req0_s = 2'd0; req0_x = 5'd3; req0_y = 5'd4; req0_cin = 1;
    #1;
    chk("t1_first_ready0", req0_ready, 1);
    chk("t1_first_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    chk("t2_busy_exec", busy, 1);
    chk("t2_rsp_valid_exec", rsp_valid, 0);
    chk("t2_alu_x", alu_x, 3);
    @(negedge clk);
    chk("t2_rsp_valid_at_N2", rsp_valid, 1);
    chk("t2_rsp_id", rsp_id, 0);
    chk("t2_rsp_f", rsp_f, 8);
    chk("t2_rsp_cout", rsp_cout, 0);
    @(negedge clk);
    chk("t2_busy_low_N3", busy, 0);
    chk("t2_rsp_f_held", rsp_f, 8);

    // contention from reset: 0,1,0,1 one grant per 3 cycles
    do_reset();
    req0_valid = 1; req0_s = 2'd2; req0_x = 5'd22; req0_y = 5'd15; req0_cin = 0;
    req1_valid = 1; req1_s = 2'd1; req1_x = 5'd7;  req1_y = 5'd9;  req1_cin = 1;
    base = acc_id.size();
    for (int i = 0; i < 20 && acc_id.size() < base + 4; i++) @(negedge clk);
    chk("t3_accept_count", (acc_id.size() >= base + 4), 1);
    if (acc_id.size() >= base + 4) begin
      chk("t3_grant0", acc_id[base],   0);
      chk("t3_grant1", acc_id[base+1], 1);
      chk("t3_grant2", acc_id[base+2], 0);
      chk("t3_grant3", acc_id[base+3], 1);
      for (int k = 1; k < 4; k++) chk("t3_spacing", acc_cyc[base+k] - acc_cyc[base+k-1], 3);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);

    // backpressure in RESP
    rsp_ready = 0;
    req0_valid = 1; req0_s = 2'd0; req0_x = 5'd31; req0_y = 5'd2; req0_cin = 0;
    req1_valid = 1;
    for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) @(negedge clk);
    chk("t4_rsp_valid_rise", rsp_valid, 1);
    sv_f = rsp_f; sv_id = rsp_id; sv_c = rsp_cout;
    n = acc_id.size();
    repeat (5) begin
      @(negedge clk);
      chk("t4_ready0_low", req0_ready, 0);
      chk("t4_ready1_low", req1_ready, 0);
      chk("t4_rsp_stable", {rsp_valid, rsp_id, rsp_cout, rsp_f}, {1'b1, sv_id, sv_c, sv_f});
    end
    chk("t4_no_accept", acc_id.size(), n);
    rsp_ready = 1;
    @(posedge clk);
    #1 h = cyc;
    for (int i = 0; i < 6 && acc_id.size() <= n; i++) @(negedge clk);
    chk("t4_resume_count", acc_id.size() > n, 1);
    if (acc_id.size() > n) chk("t4_resume_cycle", acc_cyc[n], h + 1);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);

    // reset during EXEC
    req0_valid = 1; req0_s = 2'd3; req0_x = 5'd12; req0_y = 5'd5; req0_cin = 0;
    wait_ready(0, ok);
    @(negedge clk);
    req0_valid = 0;
    chk("t5_in_exec", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_busy_cleared", busy, 0);
    chk("t5_alu_cleared", alu_x, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_response", rsp_valid, 0);
    end

    // exhaustive sweep through requester 1
    req1_valid = 1;
    for (int s = 0; s < 4; s++)
      for (int x = 0; x < 32; x++)
        for (int y = 0; y < 32; y++)
          for (int c = 0; c < 2; c++) begin
            req1_s = S'(s); req1_x = W'(x); req1_y = W'(y); req1_cin = c[0];
            wait_ready(1, ok);
            if (!ok) break;
            @(negedge clk);
          end
    req1_valid = 0;
    repeat (4) @(negedge clk);
    chk("t6_idle_after_sweep", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
